sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
- Parametrised synchronous FIFO: 2**N words deep, M bits wide. Provides occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Sits between producer and consumer in one clock domain. Drop-in successor to the team's basic FIFO buffer.
- Data width is a parameter of its own, independent of the address width.

Parameters:
- N, 3, address bits; depth = 2**N words; N >= 1
- M, 8, data width in bits; M >= 1
- AF_LVL, 2**N-1, almost_full asserts when count >= AF_LVL; legal range 1..2**N
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL; legal range 0..2**N-1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- we  in  1  write request
- wd  in  M  write data
- re  in  1  read request
- err_clr  in  1  synchronous clear of overflow/underflow
- rd  out  M  read data
- empty  out  1  count == 0
- full  out  1  count == 2**N
- almost_empty  out  1  count <= AE_LVL
- almost_full  out  1  count >= AF_LVL
- count  out  N+1  words stored, 0..2**N
- overflow  out  1  sticky: a write was refused
- underflow  out  1  sticky: a read was refused

Behaviour:
- Reset (async assert, deassert on clk edge): w_ptr=0, r_ptr=0, count=0, rd=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LVL==0 ? 1 : 0), i.e. 0 for legal values, overflow=0, underflow=0. Reset mid-operation discards all contents.
- Pointers are N+1 bits.
  - Memory index = ptr[N-1:0].
  - Wrap-around is natural modulo 2**(N+1).
  - empty = (w_ptr == r_ptr).
  - full = low N bits equal and MSBs differ.
  - count = w_ptr - r_ptr, computed modulo 2**(N+1).
- All flags and count derive only from registered pointers. No combinational path from we/re to any output, except rd in FWFT mode (FWFT is the optional feature below).
- Write accept (wa) = we && (!full || ra). On wa: mem[w_ptr] <= wd and w_ptr += 1.
- Read accept (ra) = re && !empty. On ra: r_ptr += 1.
- Full with we && re: both accepted; count unchanged; the new word lands in the slot freed by the read.
- Empty with we && re: write accepted, read refused; underflow is set; count becomes 1.
- Standard mode latency:
  - rd <= mem[r_ptr] on the edge where ra occurs.
  - rd holds its value when there is no ra.
  - Write-to-first-read-data is 2 cycles: empty drops 1 cycle after the write edge, then 1 read cycle.
- overflow set on any edge with we && !wa. underflow set on any edge with re && !ra.
- err_clr clears both sticky flags. If a set event and err_clr occur on the same edge, set wins.
- Parameter range violations are caught by an elaboration-time assertion.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN
- Defined: first-word fall-through.
  - rd = mem[r_ptr] combinationally whenever !empty; re acts as a pop/acknowledge.
  - Data is visible the cycle after the write edge (latency 1).
  - When empty, rd holds the last popped word (0 after reset).
  - Flags, count and error rules are unchanged.
- Undefined: standard registered-read mode as described above.

Decomposition:
- Package sync_fifo_pkg:
  - ptr_t parameterised-width helper function for pointer/count arithmetic
  - fifo_status_t struct {empty, full, almost_empty, almost_full, overflow, underflow}
  - localparam for default N/M
- Sub-module fifo_ram:
  - 2**N x M, one write port, one asynchronous read port
  - No reset on storage
  - Instantiated once; the control logic stays in sync_fifo_flags.

Test Plan (N=2 depth 4, M=8, AF_LVL=3, AE_LVL=1, standard mode unless noted):
- Reset then idle -> empty=1, almost_empty=1, count=0, rd=8'h00, all others 0.
- Write 8'hA1, A2, A3, A4 on consecutive cycles -> count 1,2,3,4. almost_empty drops when count reaches 2. almost_full rises at count 3; full rises at count 4. A 5th write of 8'hA5 -> overflow=1, count stays 4.
- Read 4 from full -> rd = A1, A2, A3, A4, each one cycle after re. A 5th re -> underflow=1, rd holds A4, empty=1.
- Full, then we=re=1 with wd=8'hB0 -> count stays 4; draining yields A2, A3, A4, B0. Empty, then we=re=1 -> count=1, underflow=1.
- Push/pop 10 words so the pointers wrap -> data order is preserved and count/flags are correct across the wrap. err_clr pulse -> overflow=0, underflow=0.
- With SYNC_FIFO_FWFT_EN: write 8'hC3 -> rd=C3 the next cycle with no re; re -> empty=1 and rd stays C3. Assert reset mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared definitions for the sync_fifo_flags FIFO:
//   - DEF_N / DEF_M   default address / data widths
//   - fifo_status_t   bundle of the status flags driven by the FIFO
//   - ptr_t()         pointer difference reduced modulo 2**bits. Used for
//                     occupancy from the two (N+1)-bit pointers.
package sync_fifo_pkg;

   localparam int DEF_N = 3;
   localparam int DEF_M = 8;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   // (a - b) mod 2**bits. Callers zero-extend to 32 bits and truncate the
   // result back to their own pointer width. bits == 32 gives an all-ones mask.
   function automatic logic [31:0] ptr_t(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input int unsigned bits);
      logic [31:0] mask;
      mask = (32'd1 << bits) - 32'd1;
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
//   2**N x M storage for sync_fifo_flags. One synchronous write port and one
//   asynchronous read port. The storage has no reset.
//   Ports:
//     clk    clock, rising edge
//     we     write enable
//     waddr  write address (N bits)
//     wd     write data (M bits)
//     raddr  read address (N bits)
//     rd     read data, combinational from raddr
module fifo_ram #(
   parameter int N = 3,
   parameter int M = 8
) (
   input  logic         clk,
   input  logic         we,
   input  logic [N-1:0] waddr,
   input  logic [M-1:0] wd,
   input  logic [N-1:0] raddr,
   output logic [M-1:0] rd
);

   logic [M-1:0] mem [2**N];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wd;
   end

   assign rd = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO, 2**N words of M bits. Outputs an occupancy count,
//   programmable almost-full/almost-empty flags, and sticky overflow/underflow
//   error flags.
//   Optional macro SYNC_FIFO_FWFT_EN selects first-word fall-through.
//     Defined:   rd shows the head word combinationally while the FIFO is
//                not empty. When empty, rd holds the last popped word.
//     Undefined: rd is registered and loads the head word on each accepted
//                read.
//   Ports:
//     clk          clock, rising edge
//     reset        asynchronous, active-high reset
//     we / wd      write request / data
//     re           read request (acts as a pop in FWFT mode)
//     err_clr      synchronous clear of overflow/underflow (a set on the same
//                  edge takes priority)
//     rd           read data
//     empty, full, almost_empty (count <= AE_LVL), almost_full (count >= AF_LVL)
//     count        words stored, 0..2**N
//     overflow     sticky: a write was refused
//     underflow    sticky: a read was refused
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int M      = DEF_M,
   parameter int AF_LVL = 2**N - 1,
   parameter int AE_LVL = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [M-1:0] wd,
   input  logic         re,
   input  logic         err_clr,
   output logic [M-1:0] rd,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [N:0]   count,
   output logic         overflow,
   output logic         underflow
);

   generate
      if (N < 1 || M < 1 || AF_LVL < 1 || AF_LVL > 2**N ||
          AE_LVL < 0 || AE_LVL > 2**N - 1) begin : g_bad_param
         $error("sync_fifo_flags: illegal parameter set");
      end
   endgenerate

   localparam logic [N:0] AF_V = (N+1)'(AF_LVL);
   localparam logic [N:0] AE_V = (N+1)'(AE_LVL);

   // The pointers carry one extra wrap bit, so full and empty can be told
   // apart while both keep the same memory index.
   logic [N:0]   w_ptr, r_ptr;
   logic [N:0]   cnt;
   logic         wa, ra;
   logic [M-1:0] ram_rd;
   logic [M-1:0] rd_q;
   logic         ovf_q, unf_q;
   fifo_status_t st;

   assign cnt = (N+1)'(ptr_t(32'(w_ptr), 32'(r_ptr), N + 1));

   // Status comes only from registered state. No path from we/re.
   always_comb begin
      st              = '0;
      st.empty        = (w_ptr == r_ptr);
      st.full         = (w_ptr[N-1:0] == r_ptr[N-1:0]) && (w_ptr[N] != r_ptr[N]);
      st.almost_empty = (cnt <= AE_V);
      st.almost_full  = (cnt >= AF_V);
      st.overflow     = ovf_q;
      st.underflow    = unf_q;
   end

   // A write to a full FIFO is accepted when a read frees a slot on the same
   // edge. The read returns the old word, because the RAM write takes effect
   // after the edge.
   assign ra = re && !st.empty;
   assign wa = we && (!st.full || ra);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr <= '0;
         r_ptr <= '0;
      end else begin
         if (wa) w_ptr <= w_ptr + 1'b1;
         if (ra) r_ptr <= r_ptr + 1'b1;
      end
   end

   // Sticky error flags. A set event wins over err_clr on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (we && !wa)   ovf_q <= 1'b1;
         else if (err_clr) ovf_q <= 1'b0;
         if (re && !ra)   unf_q <= 1'b1;
         else if (err_clr) unf_q <= 1'b0;
      end
   end

   // rd_q holds the word popped by the last accepted read. In standard mode it
   // is the read data. In FWFT mode it is shown only while the FIFO is empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   rd_q <= '0;
      else if (ra) rd_q <= ram_rd;
   end

   fifo_ram #(.N(N), .M(M)) u_ram (
      .clk   (clk),
      .we    (wa),
      .waddr (w_ptr[N-1:0]),
      .wd    (wd),
      .raddr (r_ptr[N-1:0]),
      .rd    (ram_rd)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign rd = st.empty ? rd_q : ram_rd;
`else
   assign rd = rd_q;
`endif

   assign empty        = st.empty;
   assign full         = st.full;
   assign almost_empty = st.almost_empty;
   assign almost_full  = st.almost_full;
   assign overflow     = st.overflow;
   assign underflow    = st.underflow;
   assign count        = cnt;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags
//   Self-checking bench for sync_fifo_flags (N=2, M=8, AF_LVL=3, AE_LVL=1).
//   Reference model: a queue of words plus sticky error bits and the last
//   popped word. Define SYNC_FIFO_FWFT_EN for the fall-through build.
module tb_sync_fifo_flags;

   localparam int N = 2, M = 8, AF = 3, AE = 1, D = 4;

   logic         clk = 1'b0;
   logic         reset, we, re, err_clr;
   logic [M-1:0] wd, rd;
   logic         empty, full, almost_empty, almost_full, overflow, underflow;
   logic [N:0]   count;

   always #5 clk = ~clk;

   sync_fifo_flags #(.N(N), .M(M), .AF_LVL(AF), .AE_LVL(AE)) dut (
      .clk          (clk),
      .reset        (reset),
      .we           (we),
      .wd           (wd),
      .re           (re),
      .err_clr      (err_clr),
      .rd           (rd),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [M-1:0] q[$];
   logic         m_ovf, m_unf;
   logic [M-1:0] m_last;   // last popped word

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_last = '0;
   endtask

   function automatic logic [M-1:0] exp_rd();
`ifdef SYNC_FIFO_FWFT_EN
      return (q.size() > 0) ? q[0] : m_last;
`else
      return m_last;
`endif
   endfunction

   // One clock: drive the inputs, update the model at the edge, and return
   // at the next negedge with the inputs idle.
   task automatic cyc(input logic w, input logic [M-1:0] d, input logic r, input logic c);
      bit rok, wok;
      we = w; wd = d; re = r; err_clr = c;
      @(posedge clk);
      rok = r && (q.size() > 0);
      wok = w && (q.size() < D || rok);
      if (w && !wok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && !rok) m_unf = 1'b1; else if (c) m_unf = 1'b0;
      if (rok) m_last = q.pop_front();
      if (wok) q.push_back(d);
      @(negedge clk);
      we = 1'b0; re = 1'b0; err_clr = 1'b0;
   endtask

   // Pop one word and return the word the FIFO delivered for it.
   task automatic pop(output logic [M-1:0] got);
`ifdef SYNC_FIFO_FWFT_EN
      got = rd;
      cyc(1'b0, '0, 1'b1, 1'b0);
`else
      cyc(1'b0, '0, 1'b1, 1'b0);
      got = rd;
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1; we = 1'b0; re = 1'b0; err_clr = 1'b0; wd = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
         errors++;
         $display("FAIL reset_flags actual=%b required=101000",
                  {empty, full, almost_empty, almost_full, overflow, underflow});
      end
      checks++;
      if (count !== 3'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", count); end
      checks++;
      if (rd !== 8'h00) begin errors++; $display("FAIL reset_rd actual=%h required=00", rd); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
         checks++;
         if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count actual=%0d required=%0d", count, i + 1); end
         checks++;
         if ({almost_empty, almost_full, full} !== {1'(i + 1 <= AE), 1'(i + 1 >= AF), 1'(i + 1 == D)}) begin
            errors++;
            $display("FAIL fill_flags ae/af/full actual=%b%b%b at count %0d", almost_empty, almost_full, full, i + 1);
         end
      end
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      checks++;
      if (overflow !== 1'b1 || count !== 3'd4) begin
         errors++; $display("FAIL overflow_on_full actual ovf=%b cnt=%0d required ovf=1 cnt=4", overflow, count);
      end
   endtask

   task automatic test_drain_underflow();
      logic [M-1:0] got;
      for (int i = 0; i < 4; i++) begin
         pop(got);
         checks++;
         if (got !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL drain_data actual=%h required=%h", got, 8'hA1 + 8'(i)); end
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (underflow !== 1'b1 || rd !== 8'hA4 || empty !== 1'b1) begin
         errors++; $display("FAIL underflow_on_empty actual unf=%b rd=%h empty=%b required 1/a4/1", underflow, rd, empty);
      end
   endtask

   task automatic test_full_rw();
      logic [M-1:0] got;
      logic [M-1:0] exp [4];
      exp[0] = 8'hA2; exp[1] = 8'hA3; exp[2] = 8'hA4; exp[3] = 8'hB0;
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
      cyc(1'b1, 8'hB0, 1'b1, 1'b0);
      checks++;
      if (count !== 3'd4 || overflow !== 1'b0) begin
         errors++; $display("FAIL full_rw actual cnt=%0d ovf=%b required cnt=4 ovf=0", count, overflow);
      end
      for (int i = 0; i < 4; i++) begin
         pop(got);
         checks++;
         if (got !== exp[i]) begin errors++; $display("FAIL full_rw_data actual=%h required=%h", got, exp[i]); end
      end
      cyc(1'b1, 8'hC0, 1'b1, 1'b0);
      checks++;
      if (count !== 3'd1 || underflow !== 1'b1) begin
         errors++; $display("FAIL empty_rw actual cnt=%0d unf=%b required cnt=1 unf=1", count, underflow);
      end
      pop(got);
      checks++;
      if (got !== 8'hC0) begin errors++; $display("FAIL empty_rw_data actual=%h required=c0", got); end
   endtask

   task automatic test_wrap_errclr();
      logic [M-1:0] got;
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
         cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
         checks++;
         if (count !== 3'd2 || almost_empty !== 1'b0) begin
            errors++; $display("FAIL wrap_count actual cnt=%0d ae=%b required 2/0", count, almost_empty);
         end
         pop(got);
         checks++;
         if (got !== 8'h50 + 8'(i)) begin errors++; $display("FAIL wrap_data actual=%h required=%h", got, 8'h50 + 8'(i)); end
         pop(got);
         checks++;
         if (got !== 8'h60 + 8'(i) || empty !== 1'b1) begin
            errors++; $display("FAIL wrap_data2 actual=%h empty=%b required=%h/1", got, empty, 8'h60 + 8'(i));
         end
      end
      // A read of an empty FIFO on the same edge as err_clr: the set wins.
      cyc(1'b0, '0, 1'b1, 1'b1);
      checks++;
      if (underflow !== 1'b1) begin errors++; $display("FAIL set_beats_clr actual=%b required=1", underflow); end
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'h70, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++; $display("FAIL err_clr actual ovf=%b unf=%b required 0/0", overflow, underflow);
      end
      while (q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [M-1:0] er;
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 15) == 0));
         er = exp_rd();
         checks++;
         if (count !== 3'(q.size()) ||
             {empty, full, almost_empty, almost_full} !==
             {1'(q.size() == 0), 1'(q.size() == D), 1'(q.size() <= AE), 1'(q.size() >= AF)}) begin
            errors++;
            $display("FAIL rand_status cyc %0d actual cnt=%0d e/f/ae/af=%b%b%b%b required cnt=%0d",
                     i, count, empty, full, almost_empty, almost_full, q.size());
         end
         checks++;
         if (overflow !== m_ovf || underflow !== m_unf) begin
            errors++; $display("FAIL rand_err cyc %0d actual %b%b required %b%b", i, overflow, underflow, m_ovf, m_unf);
         end
         checks++;
         if (rd !== er) begin errors++; $display("FAIL rand_rd cyc %0d actual=%h required=%h", i, rd, er); end
      end
   endtask

`ifdef SYNC_FIFO_FWFT_EN
   task automatic test_fwft();
      while (q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, 8'hC3, 1'b0, 1'b0);
      checks++;
      if (rd !== 8'hC3) begin errors++; $display("FAIL fwft_visible actual=%h required=c3", rd); end
      cyc(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (rd !== 8'hC3 || empty !== 1'b0) begin errors++; $display("FAIL fwft_hold actual=%h empty=%b", rd, empty); end
      cyc(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rd !== 8'hC3 || empty !== 1'b1) begin errors++; $display("FAIL fwft_pop actual=%h empty=%b required c3/1", rd, empty); end
   endtask
`endif

   task automatic test_reset_mid();
      logic [M-1:0] got;
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      we = 1'b1; wd = 8'h9F;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000 ||
          count !== 3'd0 || rd !== 8'h00) begin
         errors++;
         $display("FAIL async_reset actual flags=%b cnt=%0d rd=%h",
                  {empty, full, almost_empty, almost_full, overflow, underflow}, count, rd);
      end
      we = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      cyc(1'b1, 8'h3C, 1'b0, 1'b0);
      pop(got);
      checks++;
      if (got !== 8'h3C || empty !== 1'b1) begin
         errors++; $display("FAIL post_reset_data actual=%h empty=%b required=3c/1", got, empty);
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_full_rw();
      test_wrap_errclr();
      test_random();
`ifdef SYNC_FIFO_FWFT_EN
      test_fwft();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
